exmem_skid_buffer: RTL and testbench

Parametrised EX/MEM pipeline register, successor to the fixed 32-bit stage register between the ALU/demux stage and the data RAM / register-file write-back path. It adds a valid/ready handshake with a two-entry skid so the RAM side can stall without a combinational ready path upstream. It also adds a synchronous flush, the write-register address carried through the stage, and a saturating stall-cycle counter. Upstream is the ALU/demux/buffer-1 outputs; downstream is the data RAM and register-file write port.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_entry.sv | 28 ++
 rtl/exmem_skid_buffer.sv | 141 ++++++++++++++
 tb/tb_exmem_skid_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the EX/MEM skid-buffered stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W_DEF  = 16;

  // Payload layout at default widths; the top rebuilds the same field
  // order with its own parameters so any width combination packs alike.
  typedef struct packed {
    logic                  e_read_ram;
    logic                  e_write_ram;
    logic                  e_write_br;
    logic [REG_W_DEF-1:0]  wa;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] dw;
    logic [DATA_W_DEF-1:0] din;
  } payload_t;

  // Flat bit width of one payload entry.
  function automatic int payload_w(input int data_w, input int addr_w, input int reg_w);
    return 3 + reg_w + addr_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload register with load enable and synchronous active-low reset.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] data_q, data_d;

  // Next value: capture on load, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (i_load) data_d = i_d;
  end

  // Payload storage; reset clears to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign o_q = data_q;

endmodule

// File: rtl/exmem_skid_buffer.sv
// EX/MEM stage register with valid/ready handshake, two-entry skid,
// synchronous flush and a saturating stall-cycle counter.
module exmem_skid_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_flush,
  input  logic              i_uc_e_read_ram,
  input  logic              i_uc_e_write_ram,
  input  logic              i_uc_e_write_br,
  input  logic [REG_W-1:0]  i_wA,
  input  logic [ADDR_W-1:0] i_result_demux,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_DR2,
  input  logic              i_ready,
  output logic              o_valid,
  output logic              o_uc_e_read_ram,
  output logic              o_uc_e_write_ram,
  output logic              o_uc_e_write_br,
  output logic [REG_W-1:0]  o_wA,
  output logic [ADDR_W-1:0] o_address_ram,
  output logic [DATA_W-1:0] o_dW,
  output logic [DATA_W-1:0] o_din_ram,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int PW = payload_w(DATA_W, ADDR_W, REG_W);

  typedef struct packed {
    logic              e_read_ram;
    logic              e_write_ram;
    logic              e_write_br;
    logic [REG_W-1:0]  wa;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dw;
    logic [DATA_W-1:0] din;
  } pay_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;
  logic             ld_main, ld_skid, main_from_skid;
  pay_t             in_pay, main_pay, skid_pay, main_src;

  assign in_pay = '{e_read_ram: i_uc_e_read_ram, e_write_ram: i_uc_e_write_ram,
                    e_write_br: i_uc_e_write_br, wa: i_wA, addr: i_result_demux,
                    dw: i_alu_result, din: i_DR2};

  // Ready is a pure function of registered state so no path from i_ready.
  assign o_ready  = rst_n && (state_q != TWO);
  assign o_valid  = (state_q != EMPTY);
  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  // Next state and payload load controls; flush empties and loads nothing.
  always_comb begin
    state_d        = state_q;
    ld_main        = 1'b0;
    ld_skid        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d = ONE;
        ld_main = 1'b1;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_main = 1'b1;
        end else if (in_fire) begin
          state_d = TWO;
          ld_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        state_d        = ONE;
        ld_main        = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (i_flush) begin
      state_d = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Main refills from skid when draining TWO, else from upstream.
  always_comb begin
    main_src = in_pay;
    if (main_from_skid) main_src = skid_pay;
  end

  pipe_entry #(.W(PW)) u_main (
    .clk(clk), .rst_n(rst_n), .i_load(ld_main), .i_d(main_src), .o_q(main_pay)
  );

  pipe_entry #(.W(PW)) u_skid (
    .clk(clk), .rst_n(rst_n), .i_load(ld_skid), .i_d(in_pay), .o_q(skid_pay)
  );

  // Enables are gated so nothing fires downstream from an invalid head.
  assign o_uc_e_read_ram  = main_pay.e_read_ram  && o_valid;
  assign o_uc_e_write_ram = main_pay.e_write_ram && o_valid;
  assign o_uc_e_write_br  = main_pay.e_write_br  && o_valid;
  assign o_wA             = main_pay.wa;
  assign o_address_ram    = main_pay.addr;
  assign o_dW             = main_pay.dw;
  assign o_din_ram        = main_pay.din;

  // Stall counter: count blocked-head cycles, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (o_valid && !i_ready && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_exmem_skid_buffer.sv
// Randomized + directed bench for exmem_skid_buffer against a queue model.
module tb_exmem_skid_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, i_valid, i_flush, i_ready;
  logic        i_rd, i_wr, i_br;
  logic [4:0]  i_wA;
  logic [31:0] i_addr, i_alu, i_dr2;

  logic        o_ready, o_valid, o_rd, o_wr, o_br;
  logic [4:0]  o_wA;
  logic [31:0] o_addr, o_dW, o_din;
  logic [15:0] o_cnt;

  logic        c_ready, c_valid, c_rd, c_wr, c_br;
  logic [4:0]  c_wA;
  logic [31:0] c_addr, c_dW, c_din;
  logic [3:0]  c_cnt;

  exmem_skid_buffer dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
    .i_uc_e_read_ram(i_rd), .i_uc_e_write_ram(i_wr), .i_uc_e_write_br(i_br),
    .i_wA(i_wA), .i_result_demux(i_addr), .i_alu_result(i_alu), .i_DR2(i_dr2),
    .i_ready(i_ready), .o_valid(o_valid),
    .o_uc_e_read_ram(o_rd), .o_uc_e_write_ram(o_wr), .o_uc_e_write_br(o_br),
    .o_wA(o_wA), .o_address_ram(o_addr), .o_dW(o_dW), .o_din_ram(o_din),
    .o_stall_cnt(o_cnt)
  );

  exmem_skid_buffer #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(c_ready), .i_flush(i_flush),
    .i_uc_e_read_ram(i_rd), .i_uc_e_write_ram(i_wr), .i_uc_e_write_br(i_br),
    .i_wA(i_wA), .i_result_demux(i_addr), .i_alu_result(i_alu), .i_DR2(i_dr2),
    .i_ready(i_ready), .o_valid(c_valid),
    .o_uc_e_read_ram(c_rd), .o_uc_e_write_ram(c_wr), .o_uc_e_write_br(c_br),
    .o_wA(c_wA), .o_address_ram(c_addr), .o_dW(c_dW), .o_din_ram(c_din),
    .o_stall_cnt(c_cnt)
  );

  typedef struct packed {
    logic rd, wr, br;
    logic [4:0] wa;
    logic [31:0] addr, alu, dr2;
  } pay_t;

  pay_t        q[$];
  pay_t        last;
  int unsigned cnt, cnt4;
  int          tests, fails;
  bit          acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic pay_t cur_in();
    return '{rd: i_rd, wr: i_wr, br: i_br, wa: i_wA, addr: i_addr, alu: i_alu, dr2: i_dr2};
  endfunction

  task automatic rand_pay();
    i_rd = 1'($urandom); i_wr = 1'($urandom); i_br = 1'($urandom);
    i_wA = 5'($urandom); i_addr = $urandom; i_alu = $urandom; i_dr2 = $urandom;
  endtask

  // Compare both DUTs against the model's view of the head entry.
  task automatic check_outs();
    pay_t h;
    bit   v;
    v = (q.size() != 0);
    h = v ? q[0] : last;
    chk("ready", {o_ready, c_ready}, {2{rst_n && (q.size() < 2)}});
    chk("valid", {o_valid, c_valid}, {2{v}});
    chk("en",    {o_rd, o_wr, o_br, c_rd, c_wr, c_br}, {2{h.rd & v, h.wr & v, h.br & v}});
    chk("wA",    {o_wA, c_wA}, {2{h.wa}});
    chk("addr",  {o_addr, c_addr}, {2{h.addr}});
    chk("dW",    {o_dW, c_dW}, {2{h.alu}});
    chk("din",   {o_din, c_din}, {2{h.dr2}});
    chk("cnt",   o_cnt, 64'(cnt));
    chk("cnt4",  c_cnt, 64'(cnt4));
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic tick();
    bit   inf, outf;
    pay_t p;
    @(negedge clk);
    check_outs();
    inf  = i_valid && rst_n && (q.size() < 2);
    outf = (q.size() != 0) && i_ready;
    p    = cur_in();
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); last = '0; cnt = 0; cnt4 = 0; inf = 0;
    end else begin
      if ((q.size() != 0) && !i_ready) begin
        if (cnt < 65535) cnt++;
        if (cnt4 < 15) cnt4++;
      end
      if (i_flush) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(p);
      end
      if (q.size() != 0) last = q[0];
    end
    acc = inf;
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 0; i_flush = 0; i_ready = 1;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    tests = 0; fails = 0; acc = 0;
    rst_n = 0; i_valid = 1; i_flush = 0; i_ready = 1;
    rand_pay();
    @(posedge clk); #1;
    q.delete(); last = '0; cnt = 0; cnt4 = 0;

    // Reset held with traffic present.
    for (int k = 0; k < 3; k++) begin rand_pay(); tick(); end
    rst_n = 1; i_valid = 0;
    tick();

    // Streaming: 1..8 back to back, never stalled.
    i_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      rand_pay(); i_alu = 32'(k); i_valid = 1; tick();
      chk("stream_acc", 64'(acc), 64'd1);
    end
    i_valid = 0;
    tick();
    chk("stream_last", o_dW, 64'd8);
    tick();
    chk("stream_cnt", o_cnt, 64'd0);

    // Stall with A,B,C offered; C must wait for the drain.
    begin
      int idx = 0;
      i_ready = 0;
      for (int k = 0; k < 4 + 6; k++) begin
        if (k == 4) i_ready = 1;
        i_valid = (idx < 3);
        rand_pay(); i_alu = 32'hA0 + 32'(idx);
        tick();
        if (acc) idx++;
        if (k == 3) begin
          chk("stall_dW", o_dW, 64'hA0);
          chk("stall_rdy", 64'(o_ready), 64'd0);
        end
      end
      chk("stall_all", 64'(idx), 64'd3);
    end
    idle(2);

    // Flush in TWO with a new entry offered.
    i_ready = 0; i_valid = 1;
    rand_pay(); i_wr = 1; tick();
    rand_pay(); i_wr = 1; tick();
    i_flush = 1; rand_pay(); i_wr = 1; tick();
    i_flush = 0; i_valid = 0;
    chk("flush_wr", 64'(o_wr), 64'd0);
    idle(3);

    // Saturate the narrow counter, then flush, then reset.
    i_valid = 1; i_ready = 0; rand_pay(); tick();
    i_valid = 0;
    for (int k = 0; k < 20; k++) tick();
    chk("sat", c_cnt, 64'd15);
    i_flush = 1; tick(); i_flush = 0; tick();
    chk("sat_flush", c_cnt, 64'd15);
    rst_n = 0; tick(); rst_n = 1;
    chk("sat_rst", c_cnt, 64'd0);
    idle(2);

    // Reset while stalled in TWO; nothing may come out afterward.
    i_ready = 0; i_valid = 1;
    rand_pay(); tick(); rand_pay(); tick(); rand_pay(); tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_two_valid", 64'(o_valid), 64'd0);
    idle(4);

    // Random traffic with flushes and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      i_flush = ($urandom_range(0, 99) < 4);
      rst_n   = ($urandom_range(0, 99) >= 2);
      i_ready = ($urandom_range(0, 99) < 55);
      if (!(i_valid && !acc)) begin
        i_valid = ($urandom_range(0, 99) < 70);
        rand_pay();
      end
      tick();
    end
    rst_n = 1; i_flush = 0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
